pos_cell_reader: RTL

Streaming read controller placed directly downstream of one per-cell position RAM (`cell_x_y_z`, single-port, 2-cycle read latency). A `start` pulse makes it read address 0 to get the cell's particle count. It then reads addresses 1..count and delivers each packed `{posz, posy, posx}` word on a valid/ready stream to the force-evaluation filter. Read issue is credit-limited by an internal FIFO, so stalls downstream never lose RAM data in flight.

---
 rtl/pos_cell_reader_if.sv | 28 ++
 rtl/pos_cell_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pos_cell_reader_if.sv
// pos_cell_reader_if: valid/ready stream of particle position words.
// Carries the packed position, its RAM address tag and an end-of-cell flag.
interface pos_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_id;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_id,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_id,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pos_cell_reader.sv
// pos_cell_reader: reads a cell's count then its positions from a
// 2-cycle-latency RAM, streaming them out through a credit-guarded FIFO.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  pos_cell_reader_if.master     strm
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ID =
    ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_REQ,
    S_CNT_WAIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  state_t state_q, state_d;

  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] tag0_q, tag0_d;
  logic [ADDR_WIDTH-1:0] tag1_q, tag1_d;

  ent_t          mem_q [FIFO_DEPTH];
  ent_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] occ_q, occ_d;

  logic                  credit_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  fifo_valid;
  logic [ADDR_WIDTH-1:0] raw_cnt;
  ent_t                  head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign raw_cnt    = ram_q[ADDR_WIDTH-1:0];
  assign head       = mem_q[rd_q];
  assign fifo_valid = (occ_q != '0);
  assign pop        = fifo_valid & strm.out_ready;
  assign push       = vld_q[1];

  // Reads in flight plus buffered words must leave room for every return.
  assign credit_ok = (SW'(vld_q[0]) + SW'(vld_q[1]) + SW'(occ_q))
                     < SW'(FIFO_DEPTH);

  assign issue = (state_q == S_STREAM) && (cnt_q != '0) && credit_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; an empty cell spends one idle cycle in STREAM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_CNT_REQ;
      S_CNT_REQ:  state_d = S_CNT_WAIT;
      S_CNT_WAIT: if (wait_q) state_d = S_STREAM;
      S_STREAM: begin
        if (cnt_q == '0)
          state_d = S_DONE;
        else if (issue && (ptr_q == cnt_q))
          state_d = S_DRAIN;
      end
      S_DRAIN:    if (pop && head.last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Count capture, read pointer, return pipeline and FIFO next values.
  always_comb begin
    wait_d = 1'b0;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    if (state_q == S_CNT_WAIT) wait_d = ~wait_q;
    if ((state_q == S_CNT_WAIT) && wait_q) begin
      cnt_d = (raw_cnt > MAX_ID) ? MAX_ID : raw_cnt;
      ptr_d = ADDR_WIDTH'(1);
    end
    if (state_q == S_CNT_REQ) addr_d = '0;
    if (issue) begin
      addr_d = ptr_q;
      ptr_d  = ptr_q + ADDR_WIDTH'(1);
    end

    vld_d  = {vld_q[0], issue};
    tag0_d = issue ? ptr_q : tag0_q;
    tag1_d = tag0_q;

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[wr_q] = '{last: (tag1_q == cnt_q),
                      id:   tag1_q,
                      data: ram_q};
      wr_d = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      tag0_q <= '0;
      tag1_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
    end else begin
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      tag0_q <= tag0_d;
      tag1_q <= tag1_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
    end
  end

  // FIFO storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs decoded from state and FIFO head.
  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    particle_count = cnt_q;
    ram_address    = addr_d;
    ram_rden       = issue || (state_q == S_CNT_REQ);
    ram_wren       = 1'b0;
    ram_data       = '0;
    strm.out_valid = fifo_valid;
    strm.out_data  = fifo_valid ? head.data : '0;
    strm.out_id    = fifo_valid ? head.id   : '0;
    strm.out_last  = fifo_valid & head.last;
  end

endmodule
